// File: rtl/keypad_scan_ctrl.sv
// 3x4 telephone keypad scanner with frame debounce and a valid/ready key register.
// Define KEYPAD_AUTOREPEAT_EN to re-push a held key every REPEAT_FRAMES frames.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       overflow,
    input  logic       ovf_clr
);

    if (SCAN_CYCLES < 2 || SCAN_CYCLES > 16 ||
        DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 ||
        REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_param
        $error("keypad_scan_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    state_t     state, state_nxt;
    logic [3:0] slot;
    logic [1:0] idx;
    logic       sample, frame_end;
    logic [2:0] hits;
    logic [3:0] base, row_key, acc_key, frame_key;
    logic [1:0] row_cnt, acc_cnt;
    logic [2:0] total;
    logic       is_key, is_none, match;
    logic [3:0] cand, cnt, cnt_inc;
    logic       push, pop;

    assign sample    = (slot == 4'(SCAN_CYCLES - 1));
    assign frame_end = sample && (idx == 2'd3);
    assign row       = 4'b0001 << idx;

    // Row 3 only maps column b (key 0); a and c there are ignored.
    always_comb begin
        hits    = col & ((idx == 2'd3) ? 3'b010 : 3'b111);
        base    = {2'b00, idx} * 4'd3;
        row_cnt = 2'(hits[0]) + 2'(hits[1]) + 2'(hits[2]);
        row_key = 4'd0;
        if (idx == 2'd3)  row_key = 4'd0;
        else if (hits[0]) row_key = base + 4'd1;
        else if (hits[1]) row_key = base + 4'd2;
        else if (hits[2]) row_key = base + 4'd3;
    end

    assign total     = 3'(acc_cnt) + 3'(row_cnt);
    assign frame_key = (row_cnt != 2'd0) ? row_key : acc_key;
    assign is_key    = (total == 3'd1);
    assign is_none   = (total == 3'd0);
    assign match     = (frame_key == cand);
    assign cnt_inc   = cnt + 4'd1;
    assign pop       = key_valid && key_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot    <= '0;
            idx     <= '0;
            acc_cnt <= '0;
            acc_key <= '0;
        end else if (sample) begin
            slot <= '0;
            idx  <= idx + 2'd1;
            if (frame_end) begin
                acc_cnt <= '0;
                acc_key <= '0;
            end else begin
                acc_cnt <= (total > 3'd2) ? 2'd2 : total[1:0];
                if (row_cnt != 2'd0) acc_key <= row_key;
            end
        end else begin
            slot <= slot + 4'd1;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [7:0] rep, rep_inc;
    logic       rep_push;
    assign rep_inc  = rep + 8'd1;
    assign rep_push = is_key && match && (rep_inc == 8'(REPEAT_FRAMES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rep <= '0;
        else if (frame_end) begin
            if (state != HELD || !(is_key && match)) rep <= '0;
            else if (rep_push)                       rep <= '0;
            else                                     rep <= rep_inc;
        end
    end
`else
    logic rep_push;
    assign rep_push = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_end) begin
            unique case (state)
                IDLE: if (is_key)
                    state_nxt = (DEBOUNCE_FRAMES == 1) ? HELD : DEBOUNCE;
                DEBOUNCE:
                    if (!(is_key && match))               state_nxt = IDLE;
                    else if (cnt_inc == 4'(DEBOUNCE_FRAMES)) state_nxt = HELD;
                HELD: if (is_none) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        push = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE:     push = is_key && (DEBOUNCE_FRAMES == 1);
                DEBOUNCE: push = is_key && match &&
                                 (cnt_inc == 4'(DEBOUNCE_FRAMES));
                HELD:     push = rep_push;
                default:  push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (frame_end) begin
            if (state == IDLE && is_key) begin
                cand <= frame_key;
                cnt  <= 4'd1;
            end else if (state == DEBOUNCE) begin
                cnt <= (is_key && match) ? cnt_inc : 4'd0;
            end
        end
    end

    // A push while full keeps the unread code and flags the loss.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push && (!key_valid || pop)) begin
                key_valid <= 1'b1;
                key_code  <= frame_key;
            end else if (pop) begin
                key_valid <= 1'b0;
            end
            if (push && key_valid && !pop) overflow <= 1'b1;
            else if (ovf_clr)              overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed plus randomized bench for keypad_scan_ctrl against a per-frame key model.
module tb_keypad_scan_ctrl;

    localparam int SC = 4;
    localparam int DB = 3;
    localparam int RP = 8;
    localparam int FR = 4 * SC;

    logic       clock = 0;
    logic       reset_n;
    logic [2:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       overflow;
    logic       ovf_clr;

    logic [11:0] pressed;

    int errors = 0;
    int checks = 0;

    int m_st, m_cand, m_cnt, m_rep, m_code;
    bit m_valid, m_ovf;

    keypad_scan_ctrl #(
        .SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(RP)
    ) dut (
        .clock(clock), .reset_n(reset_n), .col(col), .row(row),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clock = ~clock;

    // Physical switch at row r, column c is bit r*3+c of pressed.
    function automatic logic [2:0] col_of(logic [11:0] p, logic [3:0] r);
        logic [2:0] c;
        c = 3'b000;
        for (int i = 0; i < 4; i++)
            if (r[i]) c = c | {p[i*3+2], p[i*3+1], p[i*3]};
        return c;
    endfunction

    assign col = col_of(pressed, row);

    function automatic logic [11:0] kb(int k);
        logic [11:0] v;
        v = '0;
        if (k == 0) v[10] = 1'b1;
        else        v[k-1] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cand = 0; m_cnt = 0; m_rep = 0;
        m_valid = 0; m_code = 0; m_ovf = 0;
    endtask

    // Classify the frame from the set of held switches, then apply the press rules.
    task automatic model_frame(output bit push, output int k);
        logic [11:0] mapped;
        int n;
        mapped = pressed & 12'b0101_1111_1111;
        n = $countones(mapped);
        k = 0;
        for (int p = 11; p >= 0; p--)
            if (mapped[p]) k = (p < 9) ? p + 1 : 0;
        push = 0;
        case (m_st)
            0: if (n == 1) begin
                m_cand = k; m_cnt = 1; m_rep = 0;
                if (DB == 1) begin push = 1; m_st = 2; end
                else m_st = 1;
            end
            1: if (n == 1 && k == m_cand) begin
                m_cnt++;
                if (m_cnt == DB) begin push = 1; m_st = 2; m_rep = 0; end
            end else begin
                m_st = 0; m_cnt = 0;
            end
            default: begin
                if (n == 0) m_st = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                if (n == 1 && k == m_cand) begin
                    m_rep++;
                    if (m_rep == RP) begin push = 1; m_rep = 0; end
                end else m_rep = 0;
`endif
            end
        endcase
    endtask

    task automatic run_frame(int pop_at, int clr_at);
        bit push, popped, was_valid, set;
        int k;
        for (int i = 1; i <= FR; i++) begin
            key_ready = (i == pop_at);
            ovf_clr   = (i == clr_at);
            @(posedge clock);
            #1;
            was_valid = m_valid;
            popped = (i == pop_at) && m_valid;
            push = 0;
            if (i == FR) model_frame(push, k);
            set = push && was_valid && !popped;
            if (push && (!was_valid || popped)) begin
                m_valid = 1; m_code = k;
            end else if (popped) m_valid = 0;
            if (set) m_ovf = 1;
            else if (i == clr_at) m_ovf = 0;
            if (i == pop_at && i != FR) chk("pop_valid", key_valid, m_valid);
            if (i == clr_at && i != FR) chk("clr_ovf", overflow, m_ovf);
            if (i == FR) begin
                chk("frame_valid", key_valid, m_valid);
                if (m_valid) chk("frame_code", key_code, m_code);
                chk("frame_ovf", overflow, m_ovf);
                chk("frame_row", row, 4'b0001);
            end
        end
        key_ready = 0;
        ovf_clr = 0;
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) run_frame(0, 0);
    endtask

    initial begin
        int r, seen, exp_seen;
        reset_n = 0; pressed = '0; key_ready = 0; ovf_clr = 0;
        model_reset();
        #12;
        chk("rst_row", row, 4'b0001);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clock);
        reset_n = 1;

        // 1: idle row rotation over one frame
        for (int n = 1; n <= FR; n++) begin
            @(posedge clock);
            #1;
            chk("scan_row", row, 4'b0001 << ((n / SC) % 4));
            chk("scan_valid", key_valid, 0);
            chk("scan_ovf", overflow, 0);
        end

        // 2: key 5 held, one report, pop, no re-report
        pressed = kb(5);
        frames(2);
        chk("k5_early", key_valid, 0);
        run_frame(0, 0);
        chk("k5_valid", key_valid, 1);
        chk("k5_code", key_code, 5);
        frames(2);
        run_frame(3, 0);
        chk("k5_popped", key_valid, 0);
        pressed = '0;
        frames(1);

        // 3: interrupted debounce for key 8
        pressed = kb(8); frames(1);
        pressed = '0;    frames(1);
        pressed = kb(8); frames(2);
        chk("k8_early", key_valid, 0);
        frames(1);
        chk("k8_code", key_code, 8);
        pressed = '0;
        run_frame(2, 0);

        // 4: multi-key and unmapped row-3 switch
        pressed = kb(1) | kb(9); frames(3);
        pressed = 12'b0010_0000_0000; frames(3);
        chk("multi_none", key_valid, 0);
        pressed = '0; frames(1);

        // 5: overflow while unread, then clear and pop
        pressed = kb(3); frames(3);
        pressed = '0;    frames(1);
        pressed = kb(7); frames(3);
        chk("ovf_code", key_code, 3);
        chk("ovf_set", overflow, 1);
        pressed = '0;
        run_frame(0, 5);
        chk("ovf_clr", overflow, 0);
        run_frame(5, 0);
        chk("ovf_pop", key_valid, 0);

        // 6: async reset mid-debounce with a full register and overflow set
        pressed = kb(6); frames(3);
        pressed = '0;    frames(1);
        pressed = kb(6); frames(3);
        pressed = '0;    frames(1);
        pressed = kb(2); frames(1);
        repeat (9) @(posedge clock);
        #2;
        reset_n = 0;
        #1;
        chk("arst_row", row, 4'b0001);
        chk("arst_valid", key_valid, 0);
        chk("arst_code", key_code, 0);
        chk("arst_ovf", overflow, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1;
        frames(2);
        chk("arst_fresh", key_valid, 0);
        frames(1);
        chk("arst_report", key_code, 2);
        pressed = '0;
        run_frame(1, 0);

        // Held key with the consumer popping every frame
        pressed = kb(2);
        seen = 0;
        for (int f = 1; f <= 20; f++) begin
            run_frame(8, 0);
            if (key_valid) seen |= (1 << f);
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_seen = (1 << 3) | (1 << 11) | (1 << 19);
`else
        exp_seen = (1 << 3);
`endif
        chk("hold_pushes", seen, exp_seen);
        pressed = '0;
        run_frame(8, 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      pressed = '0;
            else if (r < 8) begin
                if ($urandom_range(0, 1) == 0 || pressed == '0)
                    pressed = kb($urandom_range(0, 9));
            end
            else if (r == 8) pressed = kb($urandom_range(1, 4)) |
                                       kb($urandom_range(5, 9));
            else             pressed = 12'b1010_0000_0000;
            r = $urandom_range(0, 24);
            run_frame(r <= FR ? r : 0, $urandom_range(0, 40));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 3-column x 4-row telephone keypad encoder.
- Drives the four row lines one-hot in rotation and samples the three column lines once per row slot.
- Debounces the per-frame result over several frames and delivers one 4-bit key code per press through a valid/ready holding register.
- Sits between the raw keypad pins and the consumer logic that reads digits.

Parameters:
- SCAN_CYCLES, 4: clock cycles each row is driven; range 2..16.
- DEBOUNCE_FRAMES, 3: consecutive identical frames required to accept a key; range 1..15.
- REPEAT_FRAMES, 8: autorepeat period in frames; used only under KEYPAD_AUTOREPEAT_EN.

Ports:
- clock, input, 1: single clock; all state on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- col, input, 3: column sense; col[0]=a, col[1]=b, col[2]=c; active-high.
- row, output, 4: one-hot row drive; row[0]=d, row[1]=e, row[2]=f, row[3]=g.
- key_valid, output, 1: holding register contains an unread key.
- key_code, output, 4: key value 0..9, valid while key_valid=1.
- key_ready, input, 1: consumer accepts the key on any edge where key_valid=1.
- overflow, output, 1: sticky flag; a key was dropped because the holding register was full.
- ovf_clr, input, 1: synchronous clear of overflow.

Behaviour:
- Reset: all of the following take effect immediately, mid-operation included:
  - row=4'b0001, slot counter=0, row index=0, state=IDLE;
  - key_valid=0, key_code=0, overflow=0, candidate=0, debounce count=0.
- Scan timing:
  - The slot counter runs 0..SCAN_CYCLES-1.
  - col is sampled on the edge ending slot count SCAN_CYCLES-1.
  - The row index then advances 0→1→2→3→0, and row = 1<<index.
  - Frame = 4 slots = 4*SCAN_CYCLES cycles. The frame ends on the sample edge of row 3.
- Key map:
  - row0: a=1, b=2, c=3.
  - row1: a=4, b=5, c=6.
  - row2: a=7, b=8, c=9.
  - row3: b=0.
  - row3 with a or c is unmapped and ignored.
- Frame result, evaluated at frame end:
  - KEY(k): exactly one mapped hit in the frame.
  - NONE: zero mapped hits.
  - MULTI: more than one mapped hit, within one row or across rows.
- FSM, evaluated only at frame end:
  - IDLE:
    - KEY(k) → candidate=k, count=1.
    - If DEBOUNCE_FRAMES=1, push k and go to HELD; otherwise go to DEBOUNCE.
    - NONE or MULTI → stay in IDLE.
  - DEBOUNCE:
    - KEY(candidate) → count+1; when count reaches DEBOUNCE_FRAMES, push candidate and go to HELD.
    - Any other result → IDLE. The count clears and the new key is not adopted in this frame.
  - HELD:
    - NONE → IDLE.
    - KEY or MULTI → stay in HELD. There is no second report for the same press.
- Holding register:
  - On key_valid=1 and key_ready=1, key_valid clears next cycle.
  - Push while empty: key_code=k and key_valid=1 on the same edge.
  - Push on the same edge as a pop: the new code loads and key_valid stays 1.
  - Push while full with no pop: the old code is kept and overflow is set.
  - ovf_clr=1 clears overflow. If a set and a clear occur on the same edge, the set wins.
- Latency: a key arrives on key_valid at the frame end of the DEBOUNCE_FRAMES-th consecutive matching frame.
- col is assumed already synchronised to clock. The block adds no synchronizer.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- When defined:
  - In HELD, each KEY(candidate) frame increments a repeat counter.
  - Every REPEAT_FRAMES such frames the candidate is pushed again, subject to the same overflow rules.
  - A frame that is not KEY(candidate) resets the repeat counter.
  - NONE still returns the FSM to IDLE.
- When undefined: exactly one push per press; the repeat counter and its logic are absent.

Test Plan:
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_FRAMES=3, so one frame = 16 cycles.
1. Reset release → row sequence 0001,0010,0100,1000,0001, changing every 4 cycles; key_valid=0, overflow=0 throughout with col=0.
2. col=3'b010 whenever row=0010 (key 5), held for 5 frames, key_ready=0 → key_valid=1 and key_code=5 at the end of frame 3; no overflow. Then key_ready=1 for 1 cycle → key_valid=0 next cycle, with no re-report while the key is held.
3. Key 8 present in frame 1, absent in frame 2, present in frames 3-5 → exactly one report, code 8, at the end of frame 5.
4. Keys 1 and 9 pressed together, and separately col a during row 3 → no report after 6 frames; FSM stays in IDLE.
5. key_ready=0: press and release 3, then press and release 7 → key_code stays 3 and overflow=1. Then ovf_clr pulse → overflow=0; key_ready pulse → key_valid=0.
6. Assert reset_n=0 during DEBOUNCE frame 2 → row=0001 and all outputs 0 asynchronously; no report after release until 3 fresh frames. With KEYPAD_AUTOREPEAT_EN and key 2 held for 20 frames with key_ready=1 → pushes at the end of frames 3, 11 and 19.
